// File: rtl/drive_pkg.sv
// Shared types for the drive command arbiter: move command encoding and FSM states.
package drive_pkg;

   localparam int DEF_CMD_W   = 4;
   localparam int DEF_SPEED_W = 4;

   typedef enum logic [3:0] {
      FWD      = 4'b0000,
      TURN_L   = 4'b0001,
      TURN_R   = 4'b0010,
      BACK     = 4'b0011,
      SPIN_CCW = 4'b0100,
      SPIN_CW  = 4'b0101,
      BACK_L   = 4'b0110,
      BACK_R   = 4'b0111,
      STOP     = 4'b1000
   } move_cmd_t;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUN     = 2'd1,
      BRAKE   = 2'd2
   } drive_state_t;

endpackage

// File: rtl/speed_ramp.sv
// Free-running step tick plus a slew register that walks cur_speed one level per tick toward tgt_speed.
module speed_ramp #(
   parameter int SPEED_W  = 4,
   parameter int RAMP_DIV = 500_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SPEED_W-1:0] tgt_speed,
   input  logic               force_zero,
   output logic [SPEED_W-1:0] cur_speed
);
   localparam int DIV_W = $clog2(RAMP_DIV + 1);

   logic [DIV_W-1:0]   div_q, div_d;
   logic [SPEED_W-1:0] spd_q, spd_d;
   logic               tick;

   always_comb begin
      tick  = (div_q == DIV_W'(RAMP_DIV - 1));
      div_d = tick ? '0 : div_q + 1'b1;
      spd_d = spd_q;
      // Saturating toward target, so no wrap at either end of the range.
      if (force_zero)                   spd_d = '0;
      else if (tick && spd_q < tgt_speed) spd_d = spd_q + 1'b1;
      else if (tick && spd_q > tgt_speed) spd_d = spd_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         spd_q <= '0;
      end else begin
         div_q <= div_d;
         spd_q <= spd_d;
      end
   end

   assign cur_speed = spd_q;

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Selects one command source, brakes before direction changes, guards with a watchdog and
// e-stop, and hands (cmd, speed) frames to the UART side over valid/ready.
module drive_cmd_arbiter
   import drive_pkg::*;
#(
   parameter int NUM_SRC        = 2,
   parameter int CMD_W          = DEF_CMD_W,
   parameter int SPEED_W        = DEF_SPEED_W,
   parameter int TIMEOUT_CYCLES = 5_000_000,
   parameter int RAMP_DIV       = 500_000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [$clog2(NUM_SRC)-1:0] src_sel,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*CMD_W-1:0]   src_cmd,
   input  logic [NUM_SRC*SPEED_W-1:0] src_speed,
   input  logic                       estop,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CMD_W-1:0]           out_cmd,
   output logic [SPEED_W-1:0]         out_speed,
   output logic                       timed_out,
   output logic [1:0]                 state_o
);
   localparam int SEL_W = $clog2(NUM_SRC);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CMD_W-1:0] STOP_C = CMD_W'(STOP);

   logic rst_sync_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 1'b0;
      else        rst_sync_q <= 1'b1;
   end

   drive_state_t       state_q, state_d;
   logic [CMD_W-1:0]   cur_cmd_q, cur_cmd_d, pend_cmd_q, pend_cmd_d;
   logic [SPEED_W-1:0] tgt_q, tgt_d, pend_speed_q, pend_speed_d, cur_speed;
   logic               pend_vld_q, pend_vld_d, to_q, to_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [SEL_W-1:0]   sel_q;
   logic               out_valid_q, out_valid_d, last_vld_q, last_vld_d;
   logic [CMD_W-1:0]   out_cmd_q, out_cmd_d, last_cmd_q, last_cmd_d;
   logic [SPEED_W-1:0] out_speed_q, out_speed_d, last_speed_q, last_speed_d;
   logic               sel_valid, sel_chg, acc, wd_exp, pair_new;
   logic [CMD_W-1:0]   sel_cmd;
   logic [SPEED_W-1:0] sel_speed;

   // Out-of-range select indices match no source and so never accept.
   always_comb begin
      sel_valid = 1'b0;
      sel_cmd   = '0;
      sel_speed = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_sel == SEL_W'(i)) begin
            sel_valid = src_valid[i];
            sel_cmd   = src_cmd[i*CMD_W +: CMD_W];
            sel_speed = src_speed[i*SPEED_W +: SPEED_W];
         end
      end
   end

   assign sel_chg = (src_sel != sel_q);
   assign acc     = sel_valid && !estop && !sel_chg;
   assign wd_exp  = (state_q != STOPPED) && !acc && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d      = state_q;
      cur_cmd_d    = cur_cmd_q;
      tgt_d        = tgt_q;
      pend_vld_d   = pend_vld_q;
      pend_cmd_d   = pend_cmd_q;
      pend_speed_d = pend_speed_q;
      to_d         = to_q;
      wd_d         = (state_q == STOPPED || wd_exp) ? '0 : wd_q + 1'b1;
      unique case (state_q)
         STOPPED: if (pend_vld_q) begin
            pend_vld_d = 1'b0;
            if (pend_cmd_q != STOP_C) begin
               cur_cmd_d = pend_cmd_q;
               tgt_d     = pend_speed_q;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (pend_vld_q && pend_cmd_q == cur_cmd_q) begin
               pend_vld_d = 1'b0;
               tgt_d      = pend_speed_q;
            end else if (pend_vld_q || wd_exp) begin
               // The differing command stays pending and is resolved once speed hits zero.
               tgt_d   = '0;
               state_d = BRAKE;
            end
         end
         BRAKE: begin
            tgt_d = '0;
            if (cur_speed == '0) begin
               pend_vld_d = 1'b0;
               if (pend_vld_q && pend_cmd_q != STOP_C) begin
                  cur_cmd_d = pend_cmd_q;
                  tgt_d     = pend_speed_q;
                  state_d   = RUN;
               end else begin
                  cur_cmd_d = STOP_C;
                  state_d   = STOPPED;
               end
            end
         end
         default: state_d = STOPPED;
      endcase
      if (wd_exp) to_d = 1'b1;
      if (acc) begin
         pend_vld_d   = 1'b1;
         pend_cmd_d   = sel_cmd;
         pend_speed_d = sel_speed;
         wd_d         = '0;
         to_d         = 1'b0;
      end
      if (sel_chg) begin
         pend_vld_d = 1'b0;
         cur_cmd_d  = cur_cmd_q;
         tgt_d      = '0;
         state_d    = (state_q == STOPPED) ? STOPPED : BRAKE;
      end
      if (estop) begin
         pend_vld_d = 1'b0;
         cur_cmd_d  = STOP_C;
         tgt_d      = '0;
         wd_d       = '0;
         state_d    = STOPPED;
      end
   end

   // A frame is held until accepted; whatever pair is current when the slot frees up is sent next.
   assign pair_new = !last_vld_q || (cur_cmd_q != last_cmd_q) || (cur_speed != last_speed_q);

   always_comb begin
      out_valid_d  = out_valid_q;
      out_cmd_d    = out_cmd_q;
      out_speed_d  = out_speed_q;
      last_vld_d   = last_vld_q;
      last_cmd_d   = last_cmd_q;
      last_speed_d = last_speed_q;
      if (out_valid_q && out_ready) begin
         out_valid_d  = 1'b0;
         last_vld_d   = 1'b1;
         last_cmd_d   = out_cmd_q;
         last_speed_d = out_speed_q;
      end else if (!out_valid_q && pair_new) begin
         out_valid_d = 1'b1;
         out_cmd_d   = cur_cmd_q;
         out_speed_d = cur_speed;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q      <= STOPPED;
         cur_cmd_q    <= STOP_C;
         tgt_q        <= '0;
         pend_vld_q   <= 1'b0;
         pend_cmd_q   <= STOP_C;
         pend_speed_q <= '0;
         to_q         <= 1'b0;
         wd_q         <= '0;
         sel_q        <= '0;
         out_valid_q  <= 1'b0;
         out_cmd_q    <= STOP_C;
         out_speed_q  <= '0;
         last_vld_q   <= 1'b0;
         last_cmd_q   <= STOP_C;
         last_speed_q <= '0;
      end else begin
         state_q      <= state_d;
         cur_cmd_q    <= cur_cmd_d;
         tgt_q        <= tgt_d;
         pend_vld_q   <= pend_vld_d;
         pend_cmd_q   <= pend_cmd_d;
         pend_speed_q <= pend_speed_d;
         to_q         <= to_d;
         wd_q         <= wd_d;
         sel_q        <= src_sel;
         out_valid_q  <= out_valid_d;
         out_cmd_q    <= out_cmd_d;
         out_speed_q  <= out_speed_d;
         last_vld_q   <= last_vld_d;
         last_cmd_q   <= last_cmd_d;
         last_speed_q <= last_speed_d;
      end
   end

   speed_ramp #(.SPEED_W(SPEED_W), .RAMP_DIV(RAMP_DIV)) u_ramp (
      .clk       (clk),
      .rst_n     (rst_sync_q),
      .tgt_speed (tgt_q),
      .force_zero(estop),
      .cur_speed (cur_speed)
   );

   assign out_valid = out_valid_q;
   assign out_cmd   = out_cmd_q;
   assign out_speed = out_speed_q;
   assign timed_out = to_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Bench for drive_cmd_arbiter: directed corner sequences, a settle-state vector table and a random phase.
module tb_drive_cmd_arbiter;
   import drive_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [0:0] src_sel = '0;
   logic [1:0] src_valid = '0;
   logic [7:0] src_cmd = '0, src_speed = '0;
   logic       estop = 1'b0, out_ready = 1'b1;
   logic       out_valid, timed_out;
   logic [3:0] out_cmd, out_speed;
   logic [1:0] state_o;

   drive_cmd_arbiter #(.NUM_SRC(2), .CMD_W(4), .SPEED_W(4), .TIMEOUT_CYCLES(100), .RAMP_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .src_sel(src_sel), .src_valid(src_valid), .src_cmd(src_cmd),
      .src_speed(src_speed), .estop(estop), .out_valid(out_valid), .out_ready(out_ready),
      .out_cmd(out_cmd), .out_speed(out_speed), .timed_out(timed_out), .state_o(state_o));

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   logic [7:0] frames[$], expq[$], canon[$];
   int stamps[$], cst[$];
   logic [7:0] last_frame = 8'hff, held = '0;
   logic hs_q = 1'b0, hold_q = 1'b0, rnd_on = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Handshake monitor: records accepted frames and checks the hold/drop rules of the output.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_q) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_pair", {out_cmd, out_speed}, held);
         end
         if (hs_q) chk("drop_after_hs", out_valid, 0);
         hs_q   = out_valid && out_ready;
         hold_q = out_valid && !out_ready;
         held   = {out_cmd, out_speed};
         if (hs_q) begin
            frames.push_back(held);
            stamps.push_back(cyc);
            last_frame = held;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rnd_on) begin
            out_ready    = 1'($urandom_range(0, 1));
            src_valid[1] = 1'($urandom_range(0, 1));
            src_cmd[7:4]   = 4'($urandom);
            src_speed[7:4] = 4'($urandom);
         end
      end
   endtask

   task automatic send(input int s, input logic [3:0] c, input logic [3:0] v);
      src_valid[s] = 1'b1;
      src_cmd[s*4 +: 4]   = c;
      src_speed[s*4 +: 4] = v;
      tick(1);
      src_valid[s] = 1'b0;
   endtask

   task automatic ex(input int n, input logic [7:0] a = 0, b = 0, c = 0, d = 0, e = 0);
      logic [7:0] v[5];
      v = '{a, b, c, d, e};
      expq.delete();
      for (int i = 0; i < n; i++) expq.push_back(v[i]);
   endtask

   // Compare recorded frames with expq, ignoring a zero-speed frame in a direction that is
   // immediately driven (e.g. FWD/0 just before FWD/1): whether it appears is a timing detail.
   task automatic chk_seq(input string nm);
      canon.delete();
      cst.delete();
      for (int i = 0; i < frames.size(); i++) begin
         if (frames[i][3:0] == 0 && frames[i][7:4] != 4'(STOP) && i + 1 < frames.size() &&
             frames[i+1][7:4] == frames[i][7:4] && frames[i+1][3:0] != 0) continue;
         canon.push_back(frames[i]);
         cst.push_back(stamps[i]);
      end
      chk({nm, "_count"}, canon.size(), expq.size());
      for (int i = 0; i < canon.size() && i < expq.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), canon[i], expq[i]);
      frames.delete();
      stamps.delete();
   endtask

   typedef struct {
      int         src;
      logic [3:0] cmd, spd, ecmd, espd;
      logic [1:0] est;
      int         wt;
   } vec_t;
   vec_t tbl[10];

   initial begin
      #500000;
      $display("FAIL global_timeout actual=%0d required=done", cyc);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int n;
      logic [3:0] rc, rs;
      tick(3);
      chk("rst_valid", out_valid, 0);
      chk("rst_cmd", out_cmd, 8);
      chk("rst_speed", out_speed, 0);
      chk("rst_to", timed_out, 0);
      chk("rst_state", state_o, 0);
      rst_n = 1'b1;
      tick(1);
      chk("first_clk_valid", out_valid, 0);
      tick(1);
      chk("second_clk_valid", out_valid, 1);
      chk("second_clk_pair", {out_cmd, out_speed}, 8'h80);
      tick(3);
      ex(1, 8'h80); chk_seq("reset_frame");

      send(0, FWD, 3);
      tick(25);
      chk("ramp_state", state_o, 1);
      ex(3, 8'h01, 8'h02, 8'h03); chk_seq("ramp_up");
      if (cst.size() >= 3) begin
         chk("ramp_gap1", cst[1] - cst[0], 4);
         chk("ramp_gap2", cst[2] - cst[1], 4);
      end

      send(0, BACK, 2);
      tick(40);
      ex(5, 8'h02, 8'h01, 8'h00, 8'h31, 8'h32); chk_seq("dir_change");
      chk("dir_state", state_o, 1);

      send(0, BACK, 3);
      tick(20);
      ex(1, 8'h33); chk_seq("same_cmd_tgt");
      tick(50);
      chk("wd_early", timed_out, 0);
      n = 0;
      while (!timed_out && n < 60) begin tick(1); n++; end
      chk("wd_fire", timed_out, 1);
      tick(30);
      ex(4, 8'h32, 8'h31, 8'h30, 8'h80); chk_seq("wd_brake");
      chk("wd_state", state_o, 0);
      send(0, FWD, 1);
      tick(2);
      chk("wd_clear", timed_out, 0);
      tick(15);
      ex(1, 8'h01); chk_seq("after_wd");

      send(0, FWD, 3);
      tick(20);
      ex(2, 8'h02, 8'h03); chk_seq("pre_estop");
      estop = 1'b1;
      tick(1);
      chk("estop_state", state_o, 0);
      send(0, BACK, 5);
      tick(5);
      estop = 1'b0;
      tick(20);
      ex(1, 8'h80); chk_seq("estop_frames");
      chk("estop_idle", state_o, 0);

      send(1, FWD, 4);
      tick(20);
      ex(0); chk_seq("unselected_src");
      chk("unsel_state", state_o, 0);
      send(0, FWD, 2);
      tick(15);
      ex(2, 8'h01, 8'h02); chk_seq("pre_selchg");
      src_sel = 1'b1;
      src_valid[1] = 1'b1; src_cmd[7:4] = FWD; src_speed[7:4] = 4'd5;
      tick(1);
      src_valid[1] = 1'b0;
      tick(30);
      ex(3, 8'h01, 8'h00, 8'h80); chk_seq("selchg_brake");
      chk("selchg_state", state_o, 0);
      src_sel = 1'b0;
      tick(3);

      out_ready = 1'b0;
      send(0, FWD, 3);
      tick(19);
      chk("coal_valid", out_valid, 1);
      chk("coal_first", {out_cmd, out_speed}, 8'h00);
      out_ready = 1'b1;
      tick(10);
      ex(1, 8'h03); chk_seq("coalesced");

      tbl[0] = '{0, FWD,      4'd5,  FWD,      4'd5,  2'd1, 20};
      tbl[1] = '{0, TURN_L,   4'd2,  TURN_L,   4'd2,  2'd1, 40};
      tbl[2] = '{1, BACK,     4'd7,  TURN_L,   4'd2,  2'd1, 10};
      tbl[3] = '{0, TURN_L,   4'd0,  TURN_L,   4'd0,  2'd1, 20};
      tbl[4] = '{0, SPIN_CW,  4'd15, SPIN_CW,  4'd15, 2'd1, 72};
      tbl[5] = '{0, STOP,     4'd9,  STOP,     4'd0,  2'd0, 75};
      tbl[6] = '{0, STOP,     4'd0,  STOP,     4'd0,  2'd0, 10};
      tbl[7] = '{0, BACK_R,   4'd4,  BACK_R,   4'd4,  2'd1, 28};
      tbl[8] = '{0, SPIN_CCW, 4'd4,  SPIN_CCW, 4'd4,  2'd1, 45};
      tbl[9] = '{0, STOP,     4'd0,  STOP,     4'd0,  2'd0, 30};
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].src, tbl[i].cmd, tbl[i].spd);
         tick(tbl[i].wt);
         chk($sformatf("tbl%0d_frame", i), last_frame, {tbl[i].ecmd, tbl[i].espd});
         chk($sformatf("tbl%0d_state", i), state_o, tbl[i].est);
         chk($sformatf("tbl%0d_idle", i), out_valid, 0);
      end
      frames.delete();
      stamps.delete();

      // Reference: once settled, the last frame is the last command (STOP forces speed 0).
      for (int i = 0; i < 12; i++) begin
         rc = 4'($urandom_range(0, 8));
         rs = 4'($urandom_range(0, 7));
         rnd_on = 1'b1;
         send(0, rc, rs);
         tick(70);
         rnd_on = 1'b0;
         src_valid[1] = 1'b0;
         out_ready = 1'b1;
         tick(8);
         chk($sformatf("rnd%0d_frame", i), last_frame, (rc == 4'(STOP)) ? 8'h80 : {rc, rs});
         chk($sformatf("rnd%0d_state", i), state_o, (rc == 4'(STOP)) ? 0 : 1);
         chk($sformatf("rnd%0d_to", i), timed_out, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
